// File: rtl/wb_mem_arbiter_pkg.sv
// Shared types, Wishbone/memory-access constants and lane-steering helpers
// for the wb_mem_arbiter block.
package wb_mem_arbiter_pkg;

  localparam logic [1:0] MEM_TYPE_BYTE  = 2'b00;
  localparam logic [1:0] MEM_TYPE_HALF  = 2'b01;
  localparam logic [1:0] MEM_TYPE_WORD  = 2'b10;
  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  // Type 2'b11 is reserved and always reported as unaligned.
  function automatic logic is_unalign(input logic [1:0] t, input logic [1:0] ofs);
    case (t)
      MEM_TYPE_BYTE: return 1'b0;
      MEM_TYPE_HALF: return ofs[0];
      MEM_TYPE_WORD: return |ofs;
      default:       return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] t, input logic [1:0] ofs);
    case (t)
      MEM_TYPE_BYTE: return 4'b0001 << ofs;
      MEM_TYPE_HALF: return 4'b0011 << ofs;
      MEM_TYPE_WORD: return 4'b1111;
      default:       return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] t, input logic [31:0] d);
    case (t)
      MEM_TYPE_BYTE: return {4{d[7:0]}};
      MEM_TYPE_HALF: return {2{d[15:0]}};
      default:       return d;
    endcase
  endfunction

  function automatic logic [31:0] fmt_rdata(input logic [1:0] t, input logic ext,
                                            input logic [1:0] ofs, input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {ofs, 3'b000};
    case (t)
      MEM_TYPE_BYTE: return {{24{ext & sh[7]}}, sh[7:0]};
      MEM_TYPE_HALF: return {{16{ext & sh[15]}}, sh[15:0]};
      default:       return sh;
    endcase
  endfunction

endpackage

// File: rtl/wb_arb_grant.sv
// Combinational grant picker: eligible vector (+ last-grant pointer) -> index.
// Define ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module wb_arb_grant #(
  parameter int CH_NUM = 3,
  parameter int IDX_W  = $clog2(CH_NUM)
) (
  input  logic [CH_NUM-1:0] eligible,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0]  ptr,
`endif
  output logic              any,
  output logic [IDX_W-1:0]  idx
);

`ifdef ARB_ROUND_ROBIN_EN
  // Search starts just after the last granted channel and wraps.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= CH_NUM; k++) begin
      if (!any && eligible[(int'(ptr) + k) % CH_NUM]) begin
        any = 1'b1;
        idx = IDX_W'((int'(ptr) + k) % CH_NUM);
      end
    end
  end
`else
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        any = 1'b1;
        idx = IDX_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/wb_mem_arbiter.sv
// N-channel CPU memory request arbiter driving one Wishbone classic master.
// Define ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed priority.
module wb_mem_arbiter
  import wb_mem_arbiter_pkg::*;
#(
  parameter int CH_NUM = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH_NUM-1:0]     req_ren,
  input  logic [CH_NUM-1:0]     req_wen,
  input  logic [32*CH_NUM-1:0]  req_addr,
  input  logic [2*CH_NUM-1:0]   req_type,
  input  logic [CH_NUM-1:0]     req_ext,
  input  logic [32*CH_NUM-1:0]  req_dout,
  input  logic [CH_NUM-1:0]     req_suspend,
  output logic [32*CH_NUM-1:0]  req_din,
  output logic [CH_NUM-1:0]     req_stall,
  output logic [CH_NUM-1:0]     req_unalign,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [29:0]           wbm_addr_o,
  output logic [2:0]            wbm_cti_o,
  output logic [1:0]            wbm_bte_o,
  output logic [3:0]            wbm_sel_o,
  output logic [31:0]           wbm_data_o,
  input  logic [31:0]           wbm_data_i,
  input  logic                  wbm_ack_i
);

  localparam int IDX_W = $clog2(CH_NUM);

  arb_state_t          state, state_nx;
  logic [CH_NUM-1:0]   eligible;
  logic                any_elig;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    grant;
  logic [29:0]         addr_q;
  logic                we_q;
  logic [3:0]          sel_q;
  logic [31:0]         wdat_q;
  logic [31:0]         din_q;
  logic [1:0]          type_q;
  logic [1:0]          ofs_q;
  logic                ext_q;
  logic [31:0]         cur_addr;
  logic [31:0]         cur_dout;
  logic [1:0]          cur_type;
  logic                cur_ext;
  logic                cur_wen;
  logic                grant_susp;
  logic                take;
  logic                capture;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    assign req_unalign[i] = is_unalign(req_type[2*i +: 2], req_addr[32*i +: 2]);
    assign eligible[i]    = (req_ren[i] | req_wen[i]) & ~req_suspend[i] & ~req_unalign[i];
    assign req_stall[i]   = eligible[i] & ~(state == ST_DONE && grant == IDX_W'(i));
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (rst)       rr_ptr <= '0;
    else if (take) rr_ptr <= pick_idx;
  end
`endif

  wb_arb_grant #(.CH_NUM(CH_NUM), .IDX_W(IDX_W)) u_grant (
    .eligible (eligible),
`ifdef ARB_ROUND_ROBIN_EN
    .ptr      (rr_ptr),
`endif
    .any      (any_elig),
    .idx      (pick_idx)
  );

  // Steer the picked channel's request and the granted channel's suspend.
  always_comb begin
    cur_addr   = '0;
    cur_dout   = '0;
    cur_type   = '0;
    cur_ext    = 1'b0;
    cur_wen    = 1'b0;
    grant_susp = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        cur_addr = req_addr[32*i +: 32];
        cur_dout = req_dout[32*i +: 32];
        cur_type = req_type[2*i +: 2];
        cur_ext  = req_ext[i];
        cur_wen  = req_wen[i];
      end
      if (grant == IDX_W'(i)) grant_susp = req_suspend[i];
    end
  end

  assign take    = (state == ST_IDLE) && any_elig;
  assign capture = (state == ST_BUS) && wbm_ack_i && !grant_susp;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (any_elig) state_nx = ST_BUS;
      ST_BUS:  if (wbm_ack_i) state_nx = grant_susp ? ST_IDLE : ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Grant stage: latch the bus cycle; ack stage: latch formatted read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant  <= '0;
      addr_q <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      wdat_q <= '0;
      din_q  <= '0;
    end else begin
      if (take) begin
        grant  <= pick_idx;
        addr_q <= cur_addr[31:2];
        we_q   <= cur_wen;
        sel_q  <= lane_sel(cur_type, cur_addr[1:0]);
        wdat_q <= lane_wdata(cur_type, cur_dout);
      end
      if (capture) din_q <= fmt_rdata(type_q, ext_q, ofs_q, wbm_data_i);
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      type_q <= cur_type;
      ofs_q  <= cur_addr[1:0];
      ext_q  <= cur_ext;
    end
  end

  always_comb begin
    req_din = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (grant == IDX_W'(i)) req_din[32*i +: 32] = din_q;
    end
  end

  assign wbm_cyc_o  = (state == ST_BUS);
  assign wbm_stb_o  = (state == ST_BUS);
  assign wbm_we_o   = we_q;
  assign wbm_addr_o = addr_q;
  assign wbm_sel_o  = sel_q;
  assign wbm_data_o = wdat_q;
  assign wbm_cti_o  = WB_CTI_CLASSIC;
  assign wbm_bte_o  = WB_BTE_LINEAR;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed cases plus randomized
// transactions against a transaction-level reference model.
module tb_wb_mem_arbiter;

  localparam int CH = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     req_ren, req_wen, req_ext, req_suspend;
  logic [32*CH-1:0]  req_addr, req_dout, req_din;
  logic [2*CH-1:0]   req_type;
  logic [CH-1:0]     req_stall, req_unalign;
  logic              wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [29:0]       wbm_addr_o;
  logic [2:0]        wbm_cti_o;
  logic [1:0]        wbm_bte_o;
  logic [3:0]        wbm_sel_o;
  logic [31:0]       wbm_data_o, wbm_data_i;

  always #5 clk = ~clk;

  wb_mem_arbiter #(.CH_NUM(CH)) dut (
    .clk(clk), .rst(rst),
    .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_type(req_type),
    .req_ext(req_ext), .req_dout(req_dout), .req_suspend(req_suspend),
    .req_din(req_din), .req_stall(req_stall), .req_unalign(req_unalign),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_addr_o(wbm_addr_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_sel_o(wbm_sel_o), .wbm_data_o(wbm_data_o), .wbm_data_i(wbm_data_i),
    .wbm_ack_i(wbm_ack_i)
  );

  // Request state per channel, as the CPU side holds it.
  logic        r_ren[CH], r_wen[CH], r_ext[CH], r_susp[CH];
  logic [31:0] r_addr[CH], r_dout[CH];
  logic [1:0]  r_type[CH];

  // Reference model state.
  logic [31:0] last_din;
  int          g_last;
  int          rr_last;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < CH; i++) begin
      req_ren[i]            = r_ren[i];
      req_wen[i]            = r_wen[i];
      req_ext[i]            = r_ext[i];
      req_suspend[i]        = r_susp[i];
      req_addr[32*i +: 32]  = r_addr[i];
      req_dout[32*i +: 32]  = r_dout[i];
      req_type[2*i +: 2]    = r_type[i];
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < CH; i++) begin
      r_ren[i] = 1'b0; r_wen[i] = 1'b0; r_ext[i] = 1'b0; r_susp[i] = 1'b0;
      r_addr[i] = '0;  r_dout[i] = '0;  r_type[i] = 2'd2;
    end
    apply();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    last_din = '0;
    g_last   = 0;
    rr_last  = 0;
  endtask

  function automatic bit m_unalign(input logic [1:0] t, input logic [31:0] a);
    return (t == 2'd3) || (t == 2'd1 && a % 2 != 0) || (t == 2'd2 && a % 4 != 0);
  endfunction

  function automatic bit m_elig(input int i);
    return (r_ren[i] || r_wen[i]) && !r_susp[i] && !m_unalign(r_type[i], r_addr[i]);
  endfunction

  function automatic logic [31:0] m_unalign_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < CH; i++) v[i] = m_unalign(r_type[i], r_addr[i]);
    return v;
  endfunction

  function automatic logic [31:0] m_stall(input int done_ch);
    logic [31:0] v = '0;
    for (int i = 0; i < CH; i++) v[i] = m_elig(i) && (i != done_ch);
    return v;
  endfunction

  function automatic int m_pick();
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= CH; k++)
      if (m_elig((rr_last + k) % CH)) return (rr_last + k) % CH;
`else
    for (int i = 0; i < CH; i++)
      if (m_elig(i)) return i;
`endif
    return -1;
  endfunction

  function automatic logic [31:0] m_sel(input logic [1:0] t, input logic [31:0] a);
    int ofs = int'(a % 4);
    if (t == 2'd0) return 32'(1 << ofs);
    if (t == 2'd1) return 32'(3 << ofs);
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] t, input logic [31:0] d);
    if (t == 2'd0) return d[7:0] * 32'h01010101;
    if (t == 2'd1) return d[15:0] * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] d, input logic [1:0] t,
                                          input logic e, input logic [31:0] a);
    longint v, span;
    v    = longint'(d) / (longint'(1) << (8 * int'(a % 4)));
    span = (t == 2'd0) ? 64'd256 : (t == 2'd1) ? 64'd65536 : 64'h1_0000_0000;
    v    = v % span;
    if (e && t != 2'd2 && v >= span / 2) v = v + 64'h1_0000_0000 - span;
    return v[31:0];
  endfunction

  task automatic check_din(input string tag);
    for (int i = 0; i < CH; i++)
      check($sformatf("%s_din%0d", tag, i), req_din[32*i +: 32], (i == g_last) ? last_din : 32'd0);
  endtask

  // Starts in an IDLE cycle with requests settled; ends in the DONE cycle,
  // or in the IDLE cycle after ack when the channel suspends mid-transfer.
  task automatic run_txn(input int ch, input int waits, input logic [31:0] bdata, input bit susp);
    check("idle_cyc", 32'(wbm_cyc_o), 32'd0);
    check("idle_stall", 32'(req_stall), m_stall(-1));
    next_cycle();
    check("bus_cycstb", 32'({wbm_cyc_o, wbm_stb_o}), 32'd3);
    check("bus_addr", 32'(wbm_addr_o), 32'(r_addr[ch][31:2]));
    check("bus_we", 32'(wbm_we_o), 32'(r_wen[ch]));
    check("bus_sel", 32'(wbm_sel_o), m_sel(r_type[ch], r_addr[ch]));
    if (r_wen[ch]) check("bus_dato", wbm_data_o, m_wdata(r_type[ch], r_dout[ch]));
    rr_last = ch;
    g_last  = ch;
    if (susp) begin
      r_susp[ch] = 1'b1;
      apply();
      #1;
      check("susp_stall", 32'(req_stall), m_stall(-1));
    end
    for (int w = 0; w < waits; w++) begin
      next_cycle();
      check("wait_cyc", 32'(wbm_cyc_o), 32'd1);
      check("wait_stall", 32'(req_stall), m_stall(-1));
    end
    wbm_ack_i  = 1'b1;
    wbm_data_i = bdata;
    next_cycle();
    wbm_ack_i  = 1'b0;
    wbm_data_i = $urandom;
    #1;
    check("post_ack_cyc", 32'(wbm_cyc_o), 32'd0);
    if (!susp) begin
      last_din = m_rdata(bdata, r_type[ch], r_ext[ch], r_addr[ch]);
      check("done_stall", 32'(req_stall), m_stall(ch));
    end
    check_din("txn");
  endtask

  task automatic set_req(input int ch, input bit wr, input logic [1:0] t, input logic [31:0] a,
                         input bit e, input logic [31:0] d);
    r_ren[ch] = !wr; r_wen[ch] = wr; r_type[ch] = t; r_addr[ch] = a; r_ext[ch] = e; r_dout[ch] = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    wbm_ack_i = 1'b0;
    wbm_data_i = '0;
    clear_all();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_cycstbwe", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 32'd0);
    check("rst_addr", 32'(wbm_addr_o), 32'd0);
    check("rst_sel", 32'(wbm_sel_o), 32'd0);
    check("rst_dato", wbm_data_o, 32'd0);
    check("rst_ctibte", 32'({wbm_cti_o, wbm_bte_o}), 32'd0);
    check_din("rst");
    rst = 1'b0;

    // WORD read, ch2, immediate ack.
    next_cycle();
    set_req(2, 0, 2'd2, 32'h100, 0, 0); apply(); #1;
    run_txn(2, 0, 32'hDEADBEEF, 0);
    check("word_din", req_din[64 +: 32], 32'hDEADBEEF);
    check("word_stall", 32'(req_stall[2]), 32'd0);
    clear_all();

    // BYTE reads at 0x103, signed and unsigned.
    next_cycle();
    set_req(0, 0, 2'd0, 32'h103, 1, 0); apply(); #1;
    run_txn(0, 1, 32'h80123456, 0);
    check("byte_sx", req_din[31:0], 32'hFFFFFF80);
    clear_all();
    next_cycle();
    set_req(0, 0, 2'd0, 32'h103, 0, 0); apply(); #1;
    run_txn(0, 2, 32'h80123456, 0);
    check("byte_zx", req_din[31:0], 32'h00000080);
    clear_all();

    // HALF write to 0x202, then misaligned HALF to 0x201.
    next_cycle();
    set_req(1, 1, 2'd1, 32'h202, 0, 32'hABCD1234); apply(); #1;
    run_txn(1, 0, 32'h5A5A5A5A, 0);
    clear_all();
    next_cycle();
    set_req(1, 1, 2'd1, 32'h201, 0, 32'h1234); apply(); #1;
    check("half_unalign", 32'(req_unalign), 32'h2);
    check("half_unalign_stall", 32'(req_stall), 32'd0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      check("half_unalign_nocyc", 32'(wbm_cyc_o), 32'd0);
    end
    clear_all();

`ifdef ARB_ROUND_ROBIN_EN
    // Pointer back to 0, then continuous requests on every channel.
    rst = 1'b1; next_cycle(); rst = 1'b0; model_reset();
    for (int i = 0; i < CH; i++) set_req(i, 0, 2'd2, 32'h10 * (i + 1), 0, 0);
    apply(); #1;
    run_txn(1, 0, 32'h1111, 0); next_cycle();
    run_txn(2, 1, 32'h2222, 0); next_cycle();
    run_txn(0, 0, 32'h3333, 0); next_cycle();
    run_txn(1, 0, 32'h4444, 0);
    clear_all();
`else
    // Fixed priority: ch0 before ch2, with an idle cycle in between.
    next_cycle();
    set_req(0, 0, 2'd2, 32'h10, 0, 0);
    set_req(2, 0, 2'd2, 32'h20, 0, 0);
    apply(); #1;
    run_txn(0, 0, 32'hA0A0A0A0, 0);
    r_ren[0] = 1'b0; apply();
    next_cycle();
    run_txn(2, 1, 32'hC2C2C2C2, 0);
    clear_all();
`endif

    // Suspend ch1 during a 3-wait-state cycle after a completed ch1 read.
    next_cycle();
    set_req(1, 0, 2'd2, 32'h40, 0, 0); apply(); #1;
    run_txn(1, 0, 32'h11112222, 0);
    clear_all();
    next_cycle();
    set_req(1, 0, 2'd2, 32'h44, 0, 0); apply(); #1;
    run_txn(1, 3, 32'h33334444, 1);
    check("susp_din1", req_din[32 +: 32], 32'h11112222);
    clear_all();

    // Reset in the middle of a bus cycle.
    next_cycle();
    set_req(0, 0, 2'd2, 32'h80, 0, 0); apply(); #1;
    next_cycle();
    check("rstbus_cyc_before", 32'(wbm_cyc_o), 32'd1);
    rst = 1'b1;
    next_cycle();
    model_reset();
    check("rstbus_cycstb", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
    check_din("rstbus");
    rst = 1'b0;
    clear_all();
    next_cycle();
    check("rstbus_idle", 32'(wbm_cyc_o), 32'd0);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      bit any_e;
      next_cycle();
      for (int i = 0; i < CH; i++) begin
        r_ren[i]  = 1'($urandom_range(0, 1));
        r_wen[i]  = ($urandom_range(0, 2) == 0);
        r_type[i] = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        r_addr[i] = $urandom;
        if ($urandom_range(0, 3) != 0)
          r_addr[i] = (r_type[i] == 2'd2) ? r_addr[i] & ~32'd3 :
                      (r_type[i] == 2'd1) ? r_addr[i] & ~32'd1 : r_addr[i];
        r_ext[i]  = 1'($urandom_range(0, 1));
        r_dout[i] = $urandom;
        r_susp[i] = ($urandom_range(0, 5) == 0);
      end
      apply(); #1;
      check("rnd_unalign", 32'(req_unalign), m_unalign_vec());
      any_e = 0;
      for (int i = 0; i < CH; i++) any_e |= m_elig(i);
      if (!any_e) begin
        check("rnd_nostall", 32'(req_stall), 32'd0);
        next_cycle();
        check("rnd_nocyc", 32'(wbm_cyc_o), 32'd0);
      end else begin
        run_txn(m_pick(), int'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 7) == 0));
      end
      clear_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
